// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: bundles the fetch port, the data port, the
// shared memory port and the two stall requests of the unified memory
// arbiter. The slave modport is the arbiter's view. The master modport is
// the view of the surrounding pipeline and memory.
interface unified_mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   // instruction-fetch port
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_ready;
   // data-memory port
   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] dm_rdata;
   logic          dm_ready;
   // shared memory port
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;
   // stall requests towards the hazard unit
   logic          stall_if;
   logic          stall_dm;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      output if_rdata, if_ready, dm_rdata, dm_ready,
      output mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_dm
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      input  if_rdata, if_ready, dm_rdata, dm_ready,
      input  mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_dm
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between the fetch
// port and the data port. Data accesses have priority. After STARVE_MAX
// consecutive data grants taken while fetch was waiting, fetch wins the next
// contested grant. Only one memory transaction is outstanding at a time:
// IDLE (grant) -> IF_BUSY/DM_BUSY (wait for mem_ack) -> RESP (ready pulse).
// Optional macro ARB_PERF_CNT_EN adds 32-bit stall-cycle counters with a
// synchronous clear input.
module unified_mem_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   unified_mem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
   ,
   input  logic                 perf_clr,
   output logic [31:0]          perf_if_stall,
   output logic [31:0]          perf_dm_stall
`endif
);

   // legal STARVE_MAX range is 1..15, so it fits the 4-bit counter
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      DM_BUSY = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [3:0]    starve_cnt;
   logic          starved;
   logic          grant_if;
   logic          grant_dm;
   logic          ack_if;
   logic          ack_dm;

   logic          mem_req_r;
   logic          mem_we_r;
   logic [AW-1:0] mem_addr_r;
   logic [DW-1:0] mem_wdata_r;
   logic [DW-1:0] if_rdata_r;
   logic          if_ready_r;
   logic [DW-1:0] dm_rdata_r;
   logic          dm_ready_r;

   logic          stall_if_w;
   logic          stall_dm_w;

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state: grant in IDLE, wait for ack while busy, one RESP cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_dm) begin
               state_nxt = DM_BUSY;
            end else if (grant_if) begin
               state_nxt = IF_BUSY;
            end
         end
         IF_BUSY, DM_BUSY: begin
            if (bus.mem_ack) begin
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // output decode: grant decision in IDLE and ack qualification while busy
   always_comb begin
      starved  = (starve_cnt == STARVE_LIM);
      grant_if = 1'b0;
      grant_dm = 1'b0;
      ack_if   = 1'b0;
      ack_dm   = 1'b0;
      case (state)
         IDLE: begin
            // data wins a contested grant unless fetch has been starved
            if (bus.dm_req && !(bus.if_req && starved)) begin
               grant_dm = 1'b1;
            end else if (bus.if_req) begin
               grant_if = 1'b1;
            end
         end
         IF_BUSY: ack_if = bus.mem_ack;
         DM_BUSY: ack_dm = bus.mem_ack;
         default: ;
      endcase
   end

   // memory request registers: loaded on grant, mem_req dropped on ack
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
      end else if (grant_dm) begin
         mem_req_r   <= 1'b1;
         mem_we_r    <= bus.dm_we;
         mem_addr_r  <= bus.dm_addr;
         mem_wdata_r <= bus.dm_wdata;
      end else if (grant_if) begin
         // fetches never write; write data is parked at zero
         mem_req_r   <= 1'b1;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= bus.if_addr;
         mem_wdata_r <= '0;
      end else if (ack_if || ack_dm) begin
         mem_req_r   <= 1'b0;
      end
   end

   // response registers: capture read data on ack, ready pulses during RESP
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         if_rdata_r <= '0;
         if_ready_r <= 1'b0;
         dm_rdata_r <= '0;
         dm_ready_r <= 1'b0;
      end else begin
         if (ack_if) begin
            if_rdata_r <= bus.mem_rdata;
         end
         if (ack_dm) begin
            dm_rdata_r <= bus.mem_rdata;
         end
         if_ready_r <= ack_if;
         dm_ready_r <= ack_dm;
      end
   end

   // starvation counter: data grants taken while fetch waits, saturating
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (grant_if) begin
         starve_cnt <= '0;
      end else if (state == IDLE && !bus.if_req) begin
         starve_cnt <= '0;
      end else if (grant_dm && bus.if_req && !starved) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   assign stall_if_w    = bus.if_req & ~if_ready_r;
   assign stall_dm_w    = bus.dm_req & ~dm_ready_r;

   assign bus.mem_req   = mem_req_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.if_rdata  = if_rdata_r;
   assign bus.if_ready  = if_ready_r;
   assign bus.dm_rdata  = dm_rdata_r;
   assign bus.dm_ready  = dm_ready_r;
   assign bus.stall_if  = stall_if_w;
   assign bus.stall_dm  = stall_dm_w;

`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_if_cnt;
   logic [31:0] perf_dm_cnt;

   // stall-cycle counters, wrapping; clear wins over increment
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_if_cnt <= '0;
         perf_dm_cnt <= '0;
      end else if (perf_clr) begin
         perf_if_cnt <= '0;
         perf_dm_cnt <= '0;
      end else begin
         perf_if_cnt <= perf_if_cnt + 32'(stall_if_w);
         perf_dm_cnt <= perf_dm_cnt + 32'(stall_dm_w);
      end
   end

   assign perf_if_stall = perf_if_cnt;
   assign perf_dm_stall = perf_dm_cnt;
`endif

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-port unified memory between the pipeline's instruction-fetch (IF) port and data-memory (MEM-stage) port. Fixed priority to data accesses, plus a starvation guard so fetch cannot be locked out indefinitely. Sequences one outstanding memory transaction at a time. Exports stall requests that the hazard unit ORs into StallF / StallD / FlushE.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits
STARVE_MAX, 4, consecutive data grants taken while fetch waits before fetch is forced to win (range 1..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
if_req  input  1  fetch request; held until if_ready
if_addr  input  AW  fetch address
if_rdata  output  DW  fetched instruction, valid while if_ready=1
if_ready  output  1  one-cycle pulse, fetch transaction complete
dm_req  input  1  data request; held until dm_ready
dm_we  input  1  1 = store, 0 = load
dm_addr  input  AW  data address
dm_wdata  input  DW  store data
dm_rdata  output  DW  load data, valid while dm_ready=1
dm_ready  output  1  one-cycle pulse, data transaction complete
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data, valid with mem_ack
mem_ack  input  1  memory completion, one cycle
stall_if  output  1  if_req & ~if_ready
stall_dm  output  1  dm_req & ~dm_ready

Behaviour:
- FSM states: IDLE, IF_BUSY, DM_BUSY, RESP.
- Reset (reset=0, async): state=IDLE. mem_req, mem_we, if_ready, dm_ready = 0. mem_addr, mem_wdata, if_rdata, dm_rdata = 0. starve_cnt = 0.
- IDLE, grant decision:
  - dm_req only -> DM_BUSY.
  - if_req only -> IF_BUSY.
  - Both requested: DM wins unless starve_cnt == STARVE_MAX; in that case IF wins.
  - Neither requested -> stay in IDLE.
- On grant, register the address, we, and wdata of the granted port. Assert mem_req from the next cycle.
- mem_we = 0 for every fetch.
- Grant-to-mem_req latency is 1 cycle. Output registers do not change while in a BUSY state.
- BUSY + mem_ack:
  - Capture mem_rdata into the granted port's rdata register. Stores capture as well; the value is don't-care.
  - Drop mem_req in the same edge. Go to RESP.
- RESP (1 cycle):
  - Pulse the granted port's ready.
  - Go to IDLE. The next grant is evaluated in that IDLE cycle.
  - Minimum back-to-back period is 3 cycles plus memory latency.
- starve_cnt (4-bit, saturating at STARVE_MAX):
  - Increment when DM is granted while if_req=1.
  - Clear when IF is granted, or when if_req=0 in IDLE.
- A requester deasserting req mid-transaction does not abort it. The transaction completes and ready still pulses; requesters must ignore it.
- mem_ack outside a BUSY state is ignored.
- stall_if and stall_dm are combinational from the inputs and the ready registers. No other combinational input-to-output paths.
- Reset asserted mid-transaction: immediate return to IDLE, mem_req=0. The memory must tolerate an abandoned request.

Optional Feature:
ARB_PERF_CNT_EN:
- Defined: adds output ports perf_if_stall[31:0] and perf_dm_stall[31:0].
  - Each counts cycles its stall output is 1.
  - Both wrap at 2^32 and are cleared by reset.
  - Extra input perf_clr: synchronous clear of both counters; clear takes precedence over increment in the same cycle.
- Undefined: the ports, counters, and perf_clr are absent. Behaviour is otherwise identical.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0000_0040; mem acks after 2 cycles with 0x2002_0005 -> mem_req rises 1 cycle after grant, mem_we=0, if_rdata=0x2002_0005 with if_ready pulse on the cycle after ack, stall_if=1 until that pulse.
- Simultaneous requests: if_req=dm_req=1, dm_we=1, dm_addr=0x0000_0100, dm_wdata=0xDEAD_BEEF -> DM served first with mem_we=1 and mem_wdata=0xDEAD_BEEF; IF served in the next grant.
- Starvation: dm_req held high continuously with if_req high, STARVE_MAX=4 -> exactly 4 DM grants, then 1 IF grant, then DM again; starve_cnt returns to 0.
- Async reset mid-transaction: reset=0 while in DM_BUSY before ack -> mem_req=0 and all ready=0 immediately; after release, a new if_req is granted normally and no stale dm_ready appears.
- Spurious ack and dropped request: mem_ack pulse in IDLE -> no ready pulse. dm_req dropped mid-transaction -> dm_ready still pulses once, FSM returns to IDLE.
- ARB_PERF_CNT_EN defined: 10-cycle fetch stall -> perf_if_stall=10. perf_clr=1 together with a stall cycle -> counter reads 0 the next cycle.
